// File: rtl/flt_pkg.sv
// rtl/flt_pkg.sv - shared binary16 types and constants for the int/float conversion paths
package flt_pkg;
  localparam int FLT_EXP_W  = 5;
  localparam int FLT_MANT_W = 10;
  localparam int FLT_BIAS   = 15;

  typedef struct packed {
    logic                  sign;
    logic [FLT_EXP_W-1:0]  exp;
    logic [FLT_MANT_W-1:0] mant;
  } flt16_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    NORM = 1'b1
  } i2f_state_t;
endpackage

// File: rtl/flt_round_pack.sv
// rtl/flt_round_pack.sv - rounds a normalized 16-bit magnitude and packs a binary16 word
module flt_round_pack
  import flt_pkg::*;
(
  input  logic                 sign,
  input  logic [FLT_EXP_W-1:0] exp,
  input  logic [15:0]          mag,
  input  logic                 round_en,
  output flt16_t               flt
);
  logic [FLT_MANT_W-1:0] mant;
  logic                  guard;
  logic                  sticky;
  logic                  rnd_up;
  logic [FLT_MANT_W:0]   mant_inc;

  assign mant     = mag[14:5];
  assign guard    = mag[4];
  assign sticky   = |mag[3:0];
  assign rnd_up   = round_en & guard & (sticky | mant[0]);
  assign mant_inc = {1'b0, mant} + {{FLT_MANT_W{1'b0}}, rnd_up};

  // An unnormalized magnitude can only be zero here, which packs to +0.
  always_comb begin
    flt = '0;
    if (mag[15]) begin
      flt.sign = sign;
      flt.exp  = mant_inc[FLT_MANT_W] ? exp + 5'd1 : exp;
      flt.mant = mant_inc[FLT_MANT_W-1:0];
    end
  end
endmodule

// File: rtl/int2flt_conv.sv
// rtl/int2flt_conv.sv - sequential 16-bit signed integer to binary16 converter
module int2flt_conv
  import flt_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic [15:0] int_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] flt_o
);
  i2f_state_t           state;
  logic                 sign;
  logic [15:0]          mag;
  logic [FLT_EXP_W-1:0] expo;
  flt16_t               packed_flt;

  flt_round_pack u_round_pack (
    .sign     (sign),
    .exp      (expo),
    .mag      (mag),
    .round_en (ROUND_EN),
    .flt      (packed_flt)
  );

  assign busy_o = (state == NORM);

  // Exponent starts at the value for a set bit 15 and counts down per shift.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state  <= IDLE;
      sign   <= 1'b0;
      mag    <= '0;
      expo   <= '0;
      done_o <= 1'b0;
      flt_o  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            sign  <= int_i[15];
            mag   <= int_i[15] ? (~int_i + 16'd1) : int_i;
            expo  <= 5'(FLT_BIAS + 15);
            state <= NORM;
          end
        end
        NORM: begin
          if (mag == 16'd0 || mag[15]) begin
            flt_o  <= packed_flt;
            done_o <= 1'b1;
            state  <= IDLE;
          end else begin
            mag  <= mag << 1;
            expo <= expo - 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_int2flt_conv.sv
// tb/tb_int2flt_conv.sv - self-checking bench for int2flt_conv with a behavioural model
module tb_int2flt_conv;
  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] int_i = 16'h0000;
  logic        busy1, done1, busy0, done0;
  logic [15:0] flt1, flt0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          cmp_en = 1'b0;

  always #5 clk_i = ~clk_i;

  int2flt_conv #(.ROUND_EN(1'b1)) dut_rnd (
    .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .int_i(int_i),
    .busy_o(busy1), .done_o(done1), .flt_o(flt1)
  );

  int2flt_conv #(.ROUND_EN(1'b0)) dut_trn (
    .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .int_i(int_i),
    .busy_o(busy0), .done_o(done0), .flt_o(flt0)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int abs_val(input logic [15:0] v);
    int m;
    m = int'($signed(v));
    return (m < 0) ? -m : m;
  endfunction

  function automatic int msb_pos(input int m);
    int e = 0;
    while ((m >> (e + 1)) != 0) e++;
    return e;
  endfunction

  // Real-valued rounding of |v| onto an 11-bit significand.
  function automatic logic [15:0] ref_conv(input logic [15:0] v, input bit rnd);
    int m, e, r, q, rem, half, ex;
    m = abs_val(v);
    if (m == 0) return 16'h0000;
    e  = msb_pos(m);
    ex = e + 15;
    if (e <= 10) begin
      q = m << (10 - e);
    end else begin
      r    = e - 10;
      q    = m >> r;
      rem  = m - (q << r);
      half = 1 << (r - 1);
      if (rnd && (rem > half || (rem == half && (q % 2) == 1))) q++;
      if (q == 2048) begin
        q = 1024;
        ex++;
      end
    end
    return {v[15], 5'(ex), 10'(q - 1024)};
  endfunction

  function automatic int ref_lat(input logic [15:0] v);
    int m;
    m = abs_val(v);
    if (m == 0) return 1;
    return 16 - msb_pos(m);
  endfunction

  logic        m_pend, m_done;
  logic [15:0] m_res1, m_res0, m_flt1, m_flt0;
  int          m_done_cyc, cyc;

  always @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      m_pend <= 1'b0; m_done <= 1'b0; m_flt1 <= '0; m_flt0 <= '0;
      m_res1 <= '0; m_res0 <= '0; m_done_cyc <= 0; cyc <= 0;
    end else begin
      cyc    <= cyc + 1;
      m_done <= 1'b0;
      if (m_pend) begin
        if (cyc + 1 == m_done_cyc) begin
          m_pend <= 1'b0; m_done <= 1'b1; m_flt1 <= m_res1; m_flt0 <= m_res0;
        end
      end else if (start_i) begin
        m_pend     <= 1'b1;
        m_done_cyc <= cyc + 1 + ref_lat(int_i);
        m_res1     <= ref_conv(int_i, 1'b1);
        m_res0     <= ref_conv(int_i, 1'b0);
      end
    end
  end

  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("busy_rnd", busy1, m_pend);
      chk("busy_trn", busy0, m_pend);
      chk("done_rnd", done1, m_done);
      chk("done_trn", done0, m_done);
      chk("flt_rnd", flt1, m_flt1);
      chk("flt_trn", flt0, m_flt0);
    end
  end

  task automatic pulse_start(input logic [15:0] v);
    start_i = 1'b1;
    int_i   = v;
    @(negedge clk_i);
    start_i = 1'b0;
    int_i   = 16'($urandom);
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy1 ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_i);
      if (done1) begin
        lat = i;
        break;
      end
      if (busy1) bcnt++;
    end
  endtask

  task automatic convert(input logic [15:0] v, input logic [15:0] e1, input logic [15:0] e0,
                         input int elat);
    int lat, bcnt;
    @(negedge clk_i);
    pulse_start(v);
    wait_done(lat, bcnt);
    chk("latency", lat, elat);
    chk("busy_cycles", bcnt, elat);
    chk("lit_rnd", flt1, e1);
    chk("lit_trn", flt0, e0);
  endtask

  initial begin
    int lat, bcnt, dcnt;
    logic [15:0] res;

    chk("model_0803_rnd", ref_conv(16'h0803, 1'b1), 16'h6802);
    chk("model_0803_trn", ref_conv(16'h0803, 1'b0), 16'h6801);
    chk("model_7fff_rnd", ref_conv(16'h7FFF, 1'b1), 16'h7800);
    chk("model_8000", ref_conv(16'h8000, 1'b1), 16'hF800);
    chk("model_f7ff_rnd", ref_conv(16'hF7FF, 1'b1), 16'hE800);
    chk("model_lat_1", ref_lat(16'h0001), 16);

    repeat (3) @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_flt", flt1, 0);
    cmp_en = 1'b1;

    convert(16'h0000, 16'h0000, 16'h0000, 1);
    convert(16'h0001, 16'h3C00, 16'h3C00, 16);
    convert(16'h8000, 16'hF800, 16'hF800, 1);
    convert(16'h7FFF, 16'h7800, 16'h77FF, 2);
    convert(16'h0803, 16'h6802, 16'h6801, 5);
    convert(16'h0801, 16'h6800, 16'h6800, 5);
    convert(16'hF7FF, 16'hE800, 16'hE800, 5);
    convert(16'h0805, 16'h6802, 16'h6802, 5);
    convert(16'hFFFF, 16'hBC00, 16'hBC00, 16);

    // A start while busy must neither disturb nor queue behind the conversion.
    @(negedge clk_i);
    pulse_start(16'h0001);
    repeat (3) @(negedge clk_i);
    pulse_start(16'h1234);
    dcnt = 0;
    res  = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (done1) begin
        dcnt++;
        res = flt1;
      end
    end
    chk("busy_start_dones", dcnt, 1);
    chk("busy_start_res", res, 16'h3C00);

    @(negedge clk_i);
    pulse_start(16'h0000);
    @(negedge clk_i);
    chk("zero_done", done1, 1);
    pulse_start(16'h0040);
    wait_done(lat, bcnt);
    chk("done_cycle_start_lat", lat, 10);
    chk("done_cycle_start_res", flt1, 16'h5400);

    @(negedge clk_i);
    pulse_start(16'h0001);
    repeat (4) @(negedge clk_i);
    #2 reset_ni = 1'b0;
    #1;
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_done", done1, 0);
    chk("mid_rst_flt", flt1, 0);
    chk("mid_rst_flt_trn", flt0, 0);
    repeat (2) @(negedge clk_i);
    #2 reset_ni = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk_i);
      if (done1) dcnt++;
    end
    chk("no_done_after_rst", dcnt, 0);
    convert(16'h0040, 16'h5400, 16'h5400, 10);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_i);
      start_i = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: int_i = 16'($urandom);
        1: int_i = 16'($urandom) >> $urandom_range(0, 15);
        2: int_i = 16'(-int'($urandom_range(1, 3000)));
        default: begin
          case ($urandom_range(0, 5))
            0: int_i = 16'h0000;
            1: int_i = 16'h0001;
            2: int_i = 16'h8000;
            3: int_i = 16'h7FFF;
            4: int_i = 16'hFFFF;
            default: int_i = 16'h8001;
          endcase
        end
      endcase
    end
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (20) @(negedge clk_i);
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
